chip8_sprite_blit: RTL and testbench

Framebuffer writer for the CHIP-8/SCHIP core: executes one DXYN draw by reading sprite bytes, XOR-merging them into the 512×16-bit framebuffer with read-modify-write cycles, and reporting collision. The VGA scan-out reads this same framebuffer through its own port. Framebuffer layout is fixed:
- 128×64 pixels, 8 words per row, address = row*8 + word.
- Bit 15 of a word is the leftmost pixel.
- Lowres (64×32) uses rows 0..31 and words 0..3 only; scan-out scales it.

---
 rtl/chip8_sprite_blit.sv | 157 +++++++++++++++
 tb/tb_chip8_sprite_blit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_blit.sv
// rtl/chip8_sprite_blit.sv - DXYN sprite blitter: XOR read-modify-write into the 512x16 framebuffer
// One draw per accepted start; reports collision when any lit pixel is turned off.
module chip8_sprite_blit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        hires,
   input  logic [6:0]  xIn,
   input  logic [5:0]  yIn,
   input  logic [3:0]  nIn,
   output logic [4:0]  sprAddr,
   input  logic [7:0]  sprData,
   output logic [8:0]  fbAddr,
   input  logic [15:0] fbRdData,
   output logic [15:0] fbWrData,
   output logic        fbWe,
   output logic        busy,
   output logic        done,
   output logic        collision
);

   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] SPR_A  = 4'd1;
   localparam logic [3:0] SPR_B  = 4'd2;
   localparam logic [3:0] FB_RD0 = 4'd3;
   localparam logic [3:0] FB_WR0 = 4'd4;
   localparam logic [3:0] FB_RD1 = 4'd5;
   localparam logic [3:0] FB_WR1 = 4'd6;
   localparam logic [3:0] NEXT   = 4'd7;
   localparam logic [3:0] DONE   = 4'd8;

   logic [3:0]  state;
   logic        hiresR;
   logic        wide;
   logic [6:0]  xR;
   logic [5:0]  yR;
   logic [4:0]  rowCount;
   logic [4:0]  row;
   logic [7:0]  hiByte;
   logic [7:0]  loByte;

   logic [6:0]  yRow;
   logic [6:0]  heightLim;
   logic [3:0]  wordNext;
   logic        rightClip;
   logic [15:0] pattern;
   logic [31:0] shifted;
   logic [15:0] maskHi;
   logic [15:0] maskLo;
   logic [4:0]  rowNext;

   // yRow is kept 7 bits wide so the bottom-clip compare sees rows past 63
   always_comb begin
      yRow      = {1'b0, yR} + {2'b00, row};
      heightLim = hiresR ? 7'd64 : 7'd32;
      wordNext  = {1'b0, xR[6:4]} + 4'd1;
      rightClip = wordNext >= (hiresR ? 4'd8 : 4'd4);
      pattern   = wide ? {hiByte, loByte} : {loByte, 8'h00};
      shifted   = {pattern, 16'h0000} >> xR[3:0];
      maskHi    = shifted[31:16];
      maskLo    = shifted[15:0];
      rowNext   = row + 5'd1;
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign fbWe = (state == FB_WR0) || (state == FB_WR1);

   // Write data is formed from the read word arriving this cycle, so fbWe and
   // fbWrData both drop the instant the state register is reset.
   always_comb begin
      fbWrData = 16'h0000;
      if (state == FB_WR0)
         fbWrData = fbRdData ^ maskHi;
      else if (state == FB_WR1)
         fbWrData = fbRdData ^ maskLo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hiresR    <= 1'b0;
         wide      <= 1'b0;
         xR        <= 7'd0;
         yR        <= 6'd0;
         rowCount  <= 5'd0;
         row       <= 5'd0;
         hiByte    <= 8'h00;
         loByte    <= 8'h00;
         sprAddr   <= 5'd0;
         fbAddr    <= 9'd0;
         collision <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  hiresR    <= hires;
                  xR        <= hires ? xIn : {1'b0, xIn[5:0]};
                  yR        <= hires ? yIn : {1'b0, yIn[4:0]};
                  wide      <= hires && (nIn == 4'd0);
                  rowCount  <= (hires && (nIn == 4'd0)) ? 5'd16 : {1'b0, nIn};
                  row       <= 5'd0;
                  collision <= 1'b0;
                  sprAddr   <= 5'd0;
                  state     <= (!hires && (nIn == 4'd0)) ? DONE : SPR_A;
               end
            end
            SPR_A: begin
               if (wide) begin
                  sprAddr <= {row[3:0], 1'b1};
                  state   <= SPR_B;
               end else begin
                  fbAddr <= {yRow[5:0], xR[6:4]};
                  state  <= FB_RD0;
               end
            end
            SPR_B: begin
               hiByte <= sprData;
               fbAddr <= {yRow[5:0], xR[6:4]};
               state  <= FB_RD0;
            end
            FB_RD0: begin
               loByte <= sprData;
               state  <= FB_WR0;
            end
            FB_WR0: begin
               if ((fbRdData & maskHi) != 16'h0000)
                  collision <= 1'b1;
               if (rightClip) begin
                  state <= NEXT;
               end else begin
                  fbAddr <= fbAddr + 9'd1;
                  state  <= FB_RD1;
               end
            end
            FB_RD1: state <= FB_WR1;
            FB_WR1: begin
               if ((fbRdData & maskLo) != 16'h0000)
                  collision <= 1'b1;
               state <= NEXT;
            end
            NEXT: begin
               row <= rowNext;
               if ((rowNext == rowCount) || ((yRow + 7'd1) >= heightLim)) begin
                  state <= DONE;
               end else begin
                  sprAddr <= wide ? {rowNext[3:0], 1'b0} : rowNext;
                  state   <= SPR_A;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_sprite_blit.sv
// tb/tb_chip8_sprite_blit.sv - directed and randomized draws against a pixel-level framebuffer model
module tb_chip8_sprite_blit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        hires = 1'b0;
   logic [6:0]  xIn = 7'd0;
   logic [5:0]  yIn = 6'd0;
   logic [3:0]  nIn = 4'd0;
   logic [4:0]  sprAddr;
   logic [7:0]  sprData;
   logic [8:0]  fbAddr;
   logic [15:0] fbRdData;
   logic [15:0] fbWrData;
   logic        fbWe;
   logic        busy;
   logic        done;
   logic        collision;

   logic [15:0] fb [512];
   logic [15:0] preset [512];
   logic [15:0] expFb [512];
   logic [7:0]  spr [32];
   logic        doLoad = 1'b0;

   int checks = 0;
   int failures = 0;
   int doneCyc;
   int nWrites;
   int busyLow;
   int wrLog[$];
   logic expColl;
   int expCyc;
   int expWr;

   chip8_sprite_blit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hires(hires),
      .xIn(xIn), .yIn(yIn), .nIn(nIn),
      .sprAddr(sprAddr), .sprData(sprData),
      .fbAddr(fbAddr), .fbRdData(fbRdData), .fbWrData(fbWrData), .fbWe(fbWe),
      .busy(busy), .done(done), .collision(collision)
   );

   always #5 clk = ~clk;

   // Synchronous RAM models: read data one cycle after the address
   always @(posedge clk) begin
      sprData  <= spr[sprAddr];
      fbRdData <= fb[fbAddr];
      if (doLoad) begin
         for (int i = 0; i < 512; i++) fb[i] <= preset[i];
      end else if (fbWe) begin
         fb[fbAddr] <= fbWrData;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic loadFb();
      @(negedge clk) doLoad = 1'b1;
      @(negedge clk) doLoad = 1'b0;
   endtask

   task automatic presetFill(input int mode);
      for (int i = 0; i < 512; i++) preset[i] = (mode == 0) ? 16'h0000 : 16'($urandom);
   endtask

   // Pixel-by-pixel reference: draw the sprite, clip at screen edges, predict timing
   task automatic model(input logic h, input int x, input int y, input int n);
      int w, hh, xx, yy, rows, width, drawn, sx, sy, a, b;
      logic isWide, clipped, pix;
      logic [7:0] b8;
      w = h ? 128 : 64;
      hh = h ? 64 : 32;
      xx = x % w;
      yy = y % hh;
      isWide = h && (n == 0);
      rows = isWide ? 16 : n;
      width = isWide ? 16 : 8;
      for (int i = 0; i < 512; i++) expFb[i] = fb[i];
      expColl = 1'b0;
      drawn = 0;
      for (int r = 0; r < rows; r++) begin
         sy = yy + r;
         if (sy >= hh) break;
         drawn++;
         for (int c = 0; c < width; c++) begin
            b8 = isWide ? spr[2 * r + c / 8] : spr[r];
            pix = b8[7 - (c % 8)];
            sx = xx + c;
            if (pix && sx < w) begin
               a = sy * 8 + sx / 16;
               b = 15 - (sx % 16);
               if (expFb[a][b]) expColl = 1'b1;
               expFb[a][b] = ~expFb[a][b];
            end
         end
      end
      clipped = ((xx / 16) + 1) >= (w / 16);
      expCyc = 1 + drawn * ((isWide ? 7 : 6) - (clipped ? 2 : 0));
      expWr = drawn * (clipped ? 1 : 2);
   endtask

   task automatic draw(input logic h, input int x, input int y, input int n, input string tag);
      int cyc, bad;
      model(h, x, y, n);
      hires = h;
      xIn = 7'(x);
      yIn = 6'(y);
      nIn = 4'(n);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      doneCyc = -1;
      nWrites = 0;
      busyLow = 0;
      wrLog.delete();
      while (cyc < 300) begin
         if (fbWe === 1'b1) begin
            nWrites++;
            wrLog.push_back(int'(fbAddr));
         end
         if (done === 1'b1) begin
            doneCyc = cyc;
            break;
         end
         if (busy !== 1'b1) busyLow++;
         @(negedge clk);
         cyc++;
      end
      check({tag, ".doneCycle"}, doneCyc, expCyc);
      check({tag, ".writes"}, nWrites, expWr);
      check({tag, ".busyDuring"}, busyLow, 0);
      check({tag, ".collision"}, collision, expColl);
      @(negedge clk);
      check({tag, ".busyAfter"}, busy, 1'b0);
      bad = 0;
      for (int i = 0; i < 512; i++) if (fb[i] !== expFb[i]) bad++;
      check({tag, ".fbWordsWrong"}, bad, 0);
   endtask

   initial begin
      int fbWeSeen;
      for (int i = 0; i < 32; i++) spr[i] = 8'h00;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.collision", collision, 1'b0);
      check("rst.fbWe", fbWe, 1'b0);
      check("rst.fbAddr", fbAddr, 9'd0);
      check("rst.fbWrData", fbWrData, 16'h0000);
      check("rst.sprAddr", sprAddr, 5'd0);
      rst_n = 1'b1;

      presetFill(0);
      loadFb();
      spr[0] = 8'hFF;
      draw(1'b0, 0, 0, 1, "lo_x0");
      check("lo_x0.word0", fb[0], 16'hFF00);
      check("lo_x0.word1", fb[1], 16'h0000);
      check("lo_x0.cycle7", doneCyc, 7);
      draw(1'b0, 0, 0, 1, "lo_x0_again");
      check("again.word0", fb[0], 16'h0000);
      check("again.collision", collision, 1'b1);

      presetFill(0);
      loadFb();
      draw(1'b0, 12, 2, 1, "lo_x12");
      check("lo_x12.addr16", fb[16], 16'h000F);
      check("lo_x12.addr17", fb[17], 16'hF000);

      presetFill(0);
      loadFb();
      for (int i = 0; i < 32; i++) spr[i] = 8'hFF;
      draw(1'b1, 120, 60, 0, "hi_clip");
      check("hi_clip.cycle21", doneCyc, 21);
      check("hi_clip.row60", fb[487], 16'h00FF);
      check("hi_clip.row63", fb[511], 16'h00FF);

      spr[0] = 8'h81;
      spr[1] = 8'h3C;
      draw(1'b0, 70, 33, 2, "lo_wrap");
      check("lo_wrap.nlog", wrLog.size(), 4);
      if (wrLog.size() == 4) begin
         check("lo_wrap.a0", wrLog[0], 8);
         check("lo_wrap.a1", wrLog[1], 9);
         check("lo_wrap.a2", wrLog[2], 16);
         check("lo_wrap.a3", wrLog[3], 17);
      end

      draw(1'b0, 5, 5, 0, "lo_n0");
      check("lo_n0.cycle1", doneCyc, 1);

      // Reset during row 1's second read; row 0 already collided
      presetFill(0);
      preset[0] = 16'h0001;
      loadFb();
      spr[0] = 8'hFF;
      spr[1] = 8'hAA;
      hires = 1'b0;
      xIn = 7'd12;
      yIn = 6'd0;
      nIn = 4'd2;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid.rd1Addr", fbAddr, 9'd9);
      check("mid.collBefore", collision, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid.fbWe", fbWe, 1'b0);
      check("mid.busy", busy, 1'b0);
      check("mid.collision", collision, 1'b0);
      fbWeSeen = 0;
      repeat (3) begin
         @(negedge clk);
         if (fbWe !== 1'b0) fbWeSeen++;
      end
      check("mid.fbWeHeld", fbWeSeen, 0);
      rst_n = 1'b1;
      check("mid.row0w0", fb[0], 16'h000E);
      check("mid.row0w1", fb[1], 16'hF000);
      check("mid.row1w0", fb[8], 16'h000A);
      check("mid.row1w1", fb[9], 16'h0000);
      draw(1'b0, 12, 0, 2, "post_rst");

      for (int k = 0; k < 30; k++) begin
         presetFill(1);
         loadFb();
         for (int i = 0; i < 32; i++) spr[i] = 8'($urandom);
         draw(1'($urandom), int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
